local_mem_mc: RTL and testbench
===============================

LOCAL_MEM_MC -- requirements
Module: local_mem_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of local-memory channels, 1..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: CSR word width; the memory line is 8*DATA_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 26: memory word address width.
REQ-004 SHALL have parameter BURSTCOUNT_WIDTH, default 7: burst count width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles before a stalled command aborts.
REQ-006 SHALL have ports:
- Clk_400  in  1  sole clock.
- SoftReset  in  1  asynchronous, active-high reset.
- cr2mem_ctrl  in  DATA_WIDTH  [0] write strobe, [1] read strobe, [11:4] byteenable, [18:16] word select, [26:20] burstcount, [31:28] channel.
- cr2mem_address  in  DATA_WIDTH  [ADDR_WIDTH-1:0] used.
- cr2mem_writedata  in  DATA_WIDTH  write word.
- mem2cr_readdata  out  DATA_WIDTH  captured read word.
- mem2cr_status  out  DATA_WIDTH  status; layout in REQ-018.
- DDR_waitrequest  in  NUM_CH  per-channel Avalon-MM waitrequest.
- DDR_readdatavalid  in  NUM_CH  per-channel readdatavalid.
- DDR_readdata  in  NUM_CH*8*DATA_WIDTH  per-channel line data.
- DDR_read, DDR_write  out  NUM_CH each  per-channel commands.
- DDR_address  out  NUM_CH*ADDR_WIDTH.
- DDR_burstcount  out  NUM_CH*BURSTCOUNT_WIDTH.
- DDR_writedata  out  NUM_CH*8*DATA_WIDTH.
- DDR_byteenable  out  NUM_CH*DATA_WIDTH.

Function
REQ-007 SHALL register the three cr2mem inputs through two flops. Commands trigger only on a 0->1 edge of bit 0 or bit 1 of the second-stage value.
REQ-008 SHALL run one shared FSM with states IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE. Only one command is in flight at a time.
REQ-009 SHALL reject a command, set err and stay in IDLE if any of these holds: channel >= NUM_CH, both strobe edges occur in the same cycle, burstcount == 0, or the FSM is not in IDLE.
REQ-010 On an accepted edge, the FSM SHALL latch the channel, address, burstcount, word select, byteenable and data, and clear data_valid, timeout and err.
REQ-011 Write path:
- WR_ISSUE drives DDR_write of the selected channel for burstcount accepted beats.
- A beat is accepted when waitrequest is low.
- Every beat carries writedata replicated 8x and byteenable replicated 8x.
- After the last beat the FSM goes to DONE.
REQ-012 Read path:
- RD_ISSUE holds DDR_read until waitrequest is low (one cycle accepted), then goes to RD_WAIT.
- RD_WAIT counts readdatavalid beats.
- The first beat's word [sel*DATA_WIDTH +: DATA_WIDTH] is captured into mem2cr_readdata.
- When the beat count reaches burstcount, the FSM sets data_valid and goes to DONE.
REQ-013 DDR_address and DDR_burstcount of the selected channel SHALL hold the latched values. Non-selected channels SHALL hold all command outputs at 0.
REQ-014 readdatavalid on a non-selected channel, or arriving outside RD_WAIT, SHALL be ignored and SHALL set the sticky stray bit.
REQ-015 DONE SHALL return to IDLE after 1 cycle. The minimum read latency from the strobe edge to data_valid is 5 cycles when there is no wait and 1-cycle memory latency.
REQ-016 mem2cr_readdata SHALL hold its value until the next accepted read.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 mem2cr_status layout: [0] data_valid, [1] busy, [2] timeout, [3] err, [4] stray, [11:8] last channel, [31:16] cycle count of the last command (saturating at 0xFFFF), other bits 0.

Reset
REQ-019 SoftReset SHALL asynchronously force:
- the FSM to IDLE;
- all DDR_* outputs, mem2cr_readdata, mem2cr_status and the counters to 0;
- the input pipeline to 0, so a held strobe re-triggers after reset release.
REQ-020 Reset mid-command SHALL abandon the command. Beats returned after reset release SHALL count as stray.

Configuration
REQ-021 Macro LOCAL_MEM_MC_TIMEOUT_EN:
- Defined: a counter runs in WR_ISSUE, RD_ISSUE and RD_WAIT. When it reaches TIMEOUT_CYCLES the FSM sets timeout, deasserts commands and goes to DONE; data_valid stays 0.
- Undefined: no counter, the FSM waits indefinitely, and status[2] reads 0.

Verification
REQ-022 Channel 1, write addr 0x100, data 0xA5A5_0000_DEAD_BEEF, byteenable 0xFF, burstcount 1, no wait -> DDR_write[1] high 1 cycle, DDR_writedata[1] = 8 copies, busy clears.
REQ-023 Read channel 1 addr 0x100, word select 3, return line with word3 = 0x1234 after 4 cycles -> mem2cr_readdata = 0x1234, data_valid = 1, ddr4 channel 0 untouched.
REQ-024 Read channel 0, burstcount 4, waitrequest high 10 cycles -> DDR_read held 11 cycles, 4 beats counted, data from beat 1 only.
REQ-025 Channel = 5 with NUM_CH = 2, or read and write strobes together -> err = 1, no DDR activity.
REQ-026 With LOCAL_MEM_MC_TIMEOUT_EN and TIMEOUT_CYCLES = 16, read with no readdatavalid -> timeout = 1 at cycle 16, FSM IDLE; a late beat sets stray.
REQ-027 SoftReset asserted mid-write burst (beat 2 of 4) -> all outputs 0 immediately; a new write after release completes normally.

Source files
------------

// File: rtl/local_mem_mc.sv
// CSR-driven command engine for NUM_CH Avalon-MM local-memory channels.
// Define LOCAL_MEM_MC_TIMEOUT_EN to abort stalled commands after TIMEOUT_CYCLES.
module local_mem_mc #(
   parameter int NUM_CH           = 2,
   parameter int DATA_WIDTH       = 64,
   parameter int ADDR_WIDTH       = 26,
   parameter int BURSTCOUNT_WIDTH = 7,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic                             Clk_400,
   input  logic                             SoftReset,
   input  logic [DATA_WIDTH-1:0]            cr2mem_ctrl,
   input  logic [DATA_WIDTH-1:0]            cr2mem_address,
   input  logic [DATA_WIDTH-1:0]            cr2mem_writedata,
   output logic [DATA_WIDTH-1:0]            mem2cr_readdata,
   output logic [DATA_WIDTH-1:0]            mem2cr_status,
   input  logic [NUM_CH-1:0]                DDR_waitrequest,
   input  logic [NUM_CH-1:0]                DDR_readdatavalid,
   input  logic [NUM_CH*8*DATA_WIDTH-1:0]   DDR_readdata,
   output logic [NUM_CH-1:0]                DDR_read,
   output logic [NUM_CH-1:0]                DDR_write,
   output logic [NUM_CH*ADDR_WIDTH-1:0]     DDR_address,
   output logic [NUM_CH*BURSTCOUNT_WIDTH-1:0] DDR_burstcount,
   output logic [NUM_CH*8*DATA_WIDTH-1:0]   DDR_writedata,
   output logic [NUM_CH*DATA_WIDTH-1:0]     DDR_byteenable
);

   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;
   localparam int BW = BURSTCOUNT_WIDTH;
   localparam int LW = 8 * DATA_WIDTH;
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {
      IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE
   } state_t;

   state_t state, nxt;

   logic [DW-1:0] c1, c2, a1, a2, w1, w2;
   logic [1:0]    stb_q;
   logic [CW-1:0] ch_q;
   logic [AW-1:0] addr_q;
   logic [BW-1:0] bc_q, beat_q;
   logic [2:0]    sel_q;
   logic [7:0]    be_q;
   logic [DW-1:0] wd_q, rdata;
   logic [15:0]   cyc, cyc_last;
   logic          dv, to, err, stray;

   logic wr_e, rd_e, any_e, bad, accept;
   logic work, last, sel_wait, sel_rdv, stray_hit;
   logic wr_acc, rd_acc, rd_beat, to_hit;
   logic [NUM_CH-1:0] own;
   logic [DW-1:0] rd_word, be_line;

`ifdef LOCAL_MEM_MC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
`endif

   assign wr_e  = c2[0] & ~stb_q[0];
   assign rd_e  = c2[1] & ~stb_q[1];
   assign any_e = wr_e | rd_e;
   assign bad   = (wr_e & rd_e)
                | ({1'b0, c2[31:28]} >= 5'(NUM_CH))
                | (c2[26:20] == 7'd0)
                | (state != IDLE);
   assign accept = any_e & ~bad;

   assign work     = (state == WR_ISSUE) | (state == RD_ISSUE)
                   | (state == RD_WAIT);
   assign last     = (beat_q == bc_q - BW'(1));
   assign sel_wait = DDR_waitrequest[ch_q];
   assign sel_rdv  = DDR_readdatavalid[ch_q];
   // Only the selected channel in RD_WAIT may return beats.
   assign stray_hit = |(DDR_readdatavalid & ~own);
   assign rd_word = DDR_readdata[(int'(ch_q) * 8 + int'(sel_q)) * DW +: DW];

   always_comb begin
      be_line = '0;
      for (int i = 0; i < DW; i++) be_line[i] = be_q[i % 8];
   end

   always_ff @(posedge Clk_400 or posedge SoftReset) begin
      if (SoftReset) state <= IDLE;
      else           state <= nxt;
   end

   always_comb begin
      nxt            = state;
      DDR_read       = '0;
      DDR_write      = '0;
      DDR_address    = '0;
      DDR_burstcount = '0;
      DDR_writedata  = '0;
      DDR_byteenable = '0;
      wr_acc         = 1'b0;
      rd_acc         = 1'b0;
      rd_beat        = 1'b0;
      to_hit         = 1'b0;
      own            = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (c == int'(ch_q)) begin
            DDR_address[c*AW +: AW]    = addr_q;
            DDR_burstcount[c*BW +: BW] = bc_q;
            DDR_writedata[c*LW +: LW]  = {8{wd_q}};
            DDR_byteenable[c*DW +: DW] = be_line;
         end
      end
      unique case (state)
         IDLE: if (accept) nxt = wr_e ? WR_ISSUE : RD_ISSUE;
         WR_ISSUE: begin
            DDR_write[ch_q] = 1'b1;
            wr_acc = ~sel_wait;
            if (wr_acc && last) nxt = DONE;
         end
         RD_ISSUE: begin
            DDR_read[ch_q] = 1'b1;
            rd_acc = ~sel_wait;
            if (rd_acc) nxt = RD_WAIT;
         end
         RD_WAIT: begin
            own[ch_q] = 1'b1;
            rd_beat = sel_rdv;
            if (rd_beat && last) nxt = DONE;
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
`ifdef LOCAL_MEM_MC_TIMEOUT_EN
      // A command completing on the deadline cycle wins over the abort.
      if (work && tcnt == TW'(TIMEOUT_CYCLES - 1) && nxt != DONE) begin
         to_hit    = 1'b1;
         nxt       = DONE;
         DDR_read  = '0;
         DDR_write = '0;
         wr_acc    = 1'b0;
         rd_beat   = 1'b0;
      end
`endif
   end

   always_ff @(posedge Clk_400 or posedge SoftReset) begin
      if (SoftReset) begin
         c1 <= '0; c2 <= '0;
         a1 <= '0; a2 <= '0;
         w1 <= '0; w2 <= '0;
         stb_q    <= '0;
         ch_q     <= '0;
         addr_q   <= '0;
         bc_q     <= '0;
         beat_q   <= '0;
         sel_q    <= '0;
         be_q     <= '0;
         wd_q     <= '0;
         rdata    <= '0;
         cyc      <= '0;
         cyc_last <= '0;
         dv       <= 1'b0;
         to       <= 1'b0;
         err      <= 1'b0;
         stray    <= 1'b0;
      end else begin
         c1 <= cr2mem_ctrl;      c2 <= c1;
         a1 <= cr2mem_address;   a2 <= a1;
         w1 <= cr2mem_writedata; w2 <= w1;
         stb_q <= c2[1:0];
         if (stray_hit) stray <= 1'b1;
         if (accept) begin
            ch_q   <= CW'(c2[31:28]);
            addr_q <= a2[AW-1:0];
            bc_q   <= BW'(c2[26:20]);
            sel_q  <= c2[18:16];
            be_q   <= c2[11:4];
            wd_q   <= w2;
            beat_q <= '0;
            cyc    <= '0;
            dv     <= 1'b0;
            to     <= 1'b0;
            err    <= 1'b0;
         end else if (any_e) begin
            err <= 1'b1;
         end
         if (wr_acc || rd_beat) beat_q <= beat_q + BW'(1);
         if (rd_beat && beat_q == '0) rdata <= rd_word;
         if (rd_beat && last) dv <= 1'b1;
         if (to_hit) to <= 1'b1;
         if (work && cyc != 16'hFFFF) cyc <= cyc + 16'd1;
         if (state == DONE) cyc_last <= cyc;
      end
   end

`ifdef LOCAL_MEM_MC_TIMEOUT_EN
   always_ff @(posedge Clk_400 or posedge SoftReset) begin
      if (SoftReset)   tcnt <= '0;
      else if (accept) tcnt <= '0;
      else if (work)   tcnt <= tcnt + TW'(1);
   end
`endif

   assign mem2cr_readdata = rdata;

   always_comb begin
      mem2cr_status        = '0;
      mem2cr_status[0]     = dv;
      mem2cr_status[1]     = (state != IDLE);
      mem2cr_status[2]     = to;
      mem2cr_status[3]     = err;
      mem2cr_status[4]     = stray;
      mem2cr_status[11:8]  = 4'(ch_q);
      mem2cr_status[31:16] = cyc_last;
   end

   logic unused_ok;
   assign unused_ok = ^{c2[3:2], c2[15:12], c2[19], c2[27],
                        c2[DW-1:32], a2[DW-1:AW], rd_acc};

endmodule

// File: tb/tb_local_mem_mc.sv
// Directed bench for local_mem_mc with a behavioural Avalon-MM memory
// and a read-data scoreboard.
module tb_local_mem_mc;
   localparam int NCH = 2;
   localparam int DW  = 64;
   localparam int AW  = 26;
   localparam int BW  = 7;
   localparam int LW  = 8 * DW;

   logic Clk_400 = 1'b0;
   logic SoftReset;
   logic [DW-1:0] cr2mem_ctrl, cr2mem_address, cr2mem_writedata;
   logic [DW-1:0] mem2cr_readdata, mem2cr_status;
   logic [NCH-1:0] DDR_waitrequest, DDR_readdatavalid;
   logic [NCH*LW-1:0] DDR_readdata;
   logic [NCH-1:0] DDR_read, DDR_write;
   logic [NCH*AW-1:0] DDR_address;
   logic [NCH*BW-1:0] DDR_burstcount;
   logic [NCH*LW-1:0] DDR_writedata;
   logic [NCH*DW-1:0] DDR_byteenable;

   always #5 Clk_400 = ~Clk_400;

   local_mem_mc #(
      .NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .BURSTCOUNT_WIDTH(BW), .TIMEOUT_CYCLES(16)
   ) dut (
      .Clk_400(Clk_400), .SoftReset(SoftReset),
      .cr2mem_ctrl(cr2mem_ctrl), .cr2mem_address(cr2mem_address),
      .cr2mem_writedata(cr2mem_writedata),
      .mem2cr_readdata(mem2cr_readdata), .mem2cr_status(mem2cr_status),
      .DDR_waitrequest(DDR_waitrequest),
      .DDR_readdatavalid(DDR_readdatavalid),
      .DDR_readdata(DDR_readdata),
      .DDR_read(DDR_read), .DDR_write(DDR_write),
      .DDR_address(DDR_address), .DDR_burstcount(DDR_burstcount),
      .DDR_writedata(DDR_writedata), .DDR_byteenable(DDR_byteenable)
   );

   // Memory model configuration, owned by the stimulus block.
   int cfg_wait = 0;
   int cfg_lat = 1;
   logic resp_en = 1'b1;
   logic [DW-1:0] base [NCH];
   logic [NCH-1:0] inj = '0;

   int mcnt [NCH];
   int left [NCH];
   int dly  [NCH];
   int bidx [NCH];
   logic [NCH-1:0] rdv_m;

   int wbeats [NCH];
   int wr_hi  [NCH];
   int rd_hi  [NCH];
   int rdv_n  [NCH];
   logic [LW-1:0] last_wd [NCH];
   logic [DW-1:0] last_be [NCH];
   logic [AW-1:0] last_wa [NCH];

   initial begin
      for (int c = 0; c < NCH; c++) begin
         mcnt[c] = 0; left[c] = 0; dly[c] = 0; bidx[c] = 0;
         wbeats[c] = 0; wr_hi[c] = 0; rd_hi[c] = 0; rdv_n[c] = 0;
         last_wd[c] = '0; last_be[c] = '0; last_wa[c] = '0;
      end
   end

   assign DDR_readdatavalid = rdv_m | inj;

   always_comb begin
      DDR_waitrequest = '0;
      rdv_m = '0;
      DDR_readdata = '0;
      for (int c = 0; c < NCH; c++) begin
         DDR_waitrequest[c] = (DDR_read[c] | DDR_write[c]) && (mcnt[c] < cfg_wait);
         rdv_m[c] = (left[c] != 0) && (dly[c] == 0);
         for (int w = 0; w < 8; w++)
            DDR_readdata[c*LW + w*DW +: DW] = base[c] + 64'(w) + 64'(bidx[c]) * 64'd256;
      end
   end

   always @(posedge Clk_400) begin
      for (int c = 0; c < NCH; c++) begin
         mcnt[c] <= (DDR_read[c] | DDR_write[c]) ? mcnt[c] + 1 : 0;
         if (DDR_read[c] && !DDR_waitrequest[c] && resp_en) begin
            left[c] <= int'(DDR_burstcount[c*BW +: BW]);
            dly[c]  <= cfg_lat - 1;
            bidx[c] <= 0;
         end else if (left[c] != 0) begin
            if (dly[c] != 0) dly[c] <= dly[c] - 1;
            else begin
               left[c] <= left[c] - 1;
               bidx[c] <= bidx[c] + 1;
            end
         end
         if (DDR_write[c] && !DDR_waitrequest[c]) begin
            wbeats[c]  <= wbeats[c] + 1;
            last_wd[c] <= DDR_writedata[c*LW +: LW];
            last_be[c] <= DDR_byteenable[c*DW +: DW];
            last_wa[c] <= DDR_address[c*AW +: AW];
         end
         if (DDR_write[c]) wr_hi[c] <= wr_hi[c] + 1;
         if (DDR_read[c])  rd_hi[c] <= rd_hi[c] + 1;
         if (DDR_readdatavalid[c]) rdv_n[c] <= rdv_n[c] + 1;
      end
   end

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] exp_q [$];

   task automatic chk(input string tag, input logic [LW-1:0] obs,
                      input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk_400);
      #1;
   endtask

   task automatic issue(input bit wr, input bit rd, input logic [3:0] ch,
                        input logic [2:0] sel, input logic [7:0] be,
                        input logic [6:0] bc, input logic [DW-1:0] addr,
                        input logic [DW-1:0] data);
      logic [DW-1:0] c;
      c = '0;
      c[0] = wr; c[1] = rd;
      c[11:4] = be; c[18:16] = sel;
      c[26:20] = bc; c[31:28] = ch;
      cr2mem_address = addr;
      cr2mem_writedata = data;
      cr2mem_ctrl = c;
      tick();
      c[1:0] = 2'b00;
      cr2mem_ctrl = c;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n;
      n = 0;
      tick();
      tick();
      tick();
      while (mem2cr_status[1] && n < max) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, LW'(mem2cr_status[1]), '0);
   endtask

   task automatic wait_read(input string tag, input int max);
      logic [DW-1:0] e;
      wait_idle(tag, max);
      chk({tag, "_dv"}, LW'(mem2cr_status[0]), LW'(1));
      e = exp_q.pop_front();
      chk({tag, "_data"}, LW'(mem2cr_readdata), LW'(e));
   endtask

   int s0, s1, s2, s3;
   logic [DW-1:0] d;
   logic [7:0] be;

   initial begin
      base[0] = '0;
      base[1] = '0;
      SoftReset = 1'b1;
      cr2mem_ctrl = '0;
      cr2mem_address = '0;
      cr2mem_writedata = '0;
      tick();
      tick();
      chk("rst_status", LW'(mem2cr_status), '0);
      chk("rst_rdata", LW'(mem2cr_readdata), '0);
      chk("rst_cmds", LW'({DDR_read, DDR_write}), '0);
      chk("rst_addr", LW'(DDR_address), '0);
      chk("rst_wdata", DDR_writedata[LW-1:0], '0);
      chk("rst_be", LW'(DDR_byteenable), '0);
      SoftReset = 1'b0;
      tick();
      tick();

      // Single-beat write on channel 1.
      d = 64'hA5A5_0000_DEAD_BEEF;
      be = 8'hFF;
      s0 = wbeats[1]; s1 = wr_hi[1];
      issue(1, 0, 4'd1, 3'd0, be, 7'd1, 64'h100, d);
      wait_idle("wr1", 50);
      chk("wr1_beats", LW'(wbeats[1] - s0), LW'(1));
      chk("wr1_high", LW'(wr_hi[1] - s1), LW'(1));
      chk("wr1_data", last_wd[1], {8{d}});
      chk("wr1_be", LW'(last_be[1]), LW'({8{be}}));
      chk("wr1_addr", LW'(last_wa[1]), LW'(26'h100));
      chk("wr1_err", LW'(mem2cr_status[3]), '0);
      chk("wr1_ch", LW'(mem2cr_status[11:8]), LW'(1));

      // Read channel 1, word 3, latency 4.
      base[1] = 64'h1231;
      cfg_lat = 4;
      s0 = wr_hi[0] + rd_hi[0];
      exp_q.push_back(64'h1234);
      issue(0, 1, 4'd1, 3'd3, 8'h00, 7'd1, 64'h100, '0);
      wait_read("rd1", 50);
      chk("rd1_ch0_quiet", LW'(wr_hi[0] + rd_hi[0] - s0), '0);

      // Read channel 0, burst 4, 10 wait cycles: first beat only.
      base[0] = 64'h5000;
      cfg_lat = 1;
      cfg_wait = 10;
      s0 = rd_hi[0]; s1 = rdv_n[0];
      exp_q.push_back(64'h5002);
      issue(0, 1, 4'd0, 3'd2, 8'h00, 7'd4, 64'h40, '0);
      wait_read("rd4", 100);
      chk("rd4_held", LW'(rd_hi[0] - s0), LW'(11));
      chk("rd4_beats", LW'(rdv_n[0] - s1), LW'(4));
      cfg_wait = 0;

      // A write leaves the captured read word untouched.
      d = 64'h1111_2222_3333_4444;
      be = 8'h0F;
      issue(1, 0, 4'd0, 3'd0, be, 7'd1, 64'h2A, d);
      wait_idle("wr0", 50);
      chk("wr0_rdata_hold", LW'(mem2cr_readdata), LW'(64'h5002));
      chk("wr0_be", LW'(last_be[0]), LW'({8{be}}));
      chk("wr0_data", last_wd[0], {8{d}});
      chk("wr0_addr", LW'(last_wa[0]), LW'(26'h2A));

      // Rejected commands.
      s0 = wr_hi[0] + rd_hi[0] + wr_hi[1] + rd_hi[1];
      issue(1, 0, 4'd5, 3'd0, 8'hFF, 7'd1, 64'h0, 64'h1);
      wait_idle("bad_ch", 20);
      chk("bad_ch_err", LW'(mem2cr_status[3]), LW'(1));
      issue(0, 0, 4'd0, 3'd0, 8'hFF, 7'd1, 64'h0, 64'h1);
      issue(1, 1, 4'd0, 3'd0, 8'hFF, 7'd1, 64'h0, 64'h1);
      wait_idle("both", 20);
      chk("both_err", LW'(mem2cr_status[3]), LW'(1));
      issue(1, 0, 4'd1, 3'd0, 8'hFF, 7'd0, 64'h0, 64'h1);
      wait_idle("bc0", 20);
      chk("bc0_err", LW'(mem2cr_status[3]), LW'(1));
      chk("bad_quiet", LW'(wr_hi[0] + rd_hi[0] + wr_hi[1] + rd_hi[1] - s0), '0);
      issue(1, 0, 4'd1, 3'd0, 8'hFF, 7'd1, 64'h8, 64'h77);
      wait_idle("clr", 20);
      chk("clr_err", LW'(mem2cr_status[3]), '0);

      // Command arriving while busy is rejected; the busy one completes.
      base[0] = 64'h9000;
      cfg_wait = 20;
      s0 = wbeats[1];
      exp_q.push_back(64'h9001);
      issue(0, 1, 4'd0, 3'd1, 8'h00, 7'd1, 64'h10, '0);
      issue(1, 0, 4'd1, 3'd0, 8'hFF, 7'd1, 64'h10, 64'h5);
      wait_read("busy", 100);
      chk("busy_err", LW'(mem2cr_status[3]), LW'(1));
      chk("busy_nowr", LW'(wbeats[1] - s0), '0);
      cfg_wait = 0;

      // Stray beat while idle.
      chk("stray_pre", LW'(mem2cr_status[4]), '0);
      inj = 2'b01;
      tick();
      inj = 2'b00;
      tick();
      chk("stray_idle", LW'(mem2cr_status[4]), LW'(1));

      // Reset in the middle of a 4-beat write.
      s0 = wbeats[0];
      issue(1, 0, 4'd0, 3'd0, 8'hFF, 7'd4, 64'h300, 64'hCAFE);
      s1 = 0;
      while (!(wbeats[0] - s0 == 1 && DDR_write[0]) && s1 < 20) begin
         tick();
         s1++;
      end
      chk("mid_beat", LW'(wbeats[0] - s0), LW'(1));
      SoftReset = 1'b1;
      #1;
      chk("mid_cmds", LW'({DDR_read, DDR_write}), '0);
      chk("mid_status", LW'(mem2cr_status), '0);
      chk("mid_rdata", LW'(mem2cr_readdata), '0);
      chk("mid_addr", LW'(DDR_address), '0);
      chk("mid_wdata", DDR_writedata[LW-1:0], '0);
      tick();
      tick();
      SoftReset = 1'b0;
      tick();
      d = 64'h0BAD_F00D_0000_0042;
      s2 = wbeats[1];
      issue(1, 0, 4'd1, 3'd0, 8'hFF, 7'd2, 64'h400, d);
      wait_idle("post", 50);
      chk("post_beats", LW'(wbeats[1] - s2), LW'(2));
      chk("post_data", last_wd[1], {8{d}});
      chk("post_err", LW'(mem2cr_status[3]), '0);

`ifdef LOCAL_MEM_MC_TIMEOUT_EN
      resp_en = 1'b0;
      issue(0, 1, 4'd0, 3'd0, 8'h00, 7'd1, 64'h20, '0);
      wait_idle("tmo", 100);
      chk("tmo_flag", LW'(mem2cr_status[2]), LW'(1));
      chk("tmo_dv", LW'(mem2cr_status[0]), '0);
      chk("tmo_cycles", LW'(mem2cr_status[31:16]), LW'(16));
      chk("tmo_stray_pre", LW'(mem2cr_status[4]), '0);
      inj = 2'b01;
      tick();
      inj = 2'b00;
      tick();
      chk("tmo_stray", LW'(mem2cr_status[4]), LW'(1));
      resp_en = 1'b1;
`else
      chk("no_tmo_bit", LW'(mem2cr_status[2]), '0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
